serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell walks both operand shift registers. The result
// shifts in from the MSB side. diff/bout are separate output registers, so
// they keep the previous result while a new operation is shifting.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             d_bit;
    logic             br_next;

    // Full-subtractor cell on bit 0 of the operand registers.
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    // Publish the finished word straight from the cell output.
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StShift);
    assign done  = (state_q == StDone);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    int n_checks   = 0;
    int n_pass     = 0;
    int onehot_bad = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out of reset, exactly one of ready/busy/done must be high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && $countones({ready, busy, done}) != 1) onehot_bad++;
    end

    // Reference: {bout,diff} is a - b - bin in 5-bit two's complement.
    function automatic logic [4:0] ref_sub(input logic [3:0] xa, input logic [3:0] xb,
                                           input logic xbin);
        int r;
        r = int'(xa) - int'(xb) - int'(xbin);
        return 5'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Run one operation from an IDLE negedge; checks latency, busy length,
    // result, hold of previous result during SHIFT, and the single-cycle done.
    task automatic do_op(input logic [3:0] xa, input logic [3:0] xb, input logic xbin,
                         input string tag);
        int         n;
        int         edges;
        int         busy_cnt;
        int         hold_bad;
        logic [4:0] prev;
        logic [4:0] exp;
        exp = ref_sub(xa, xb, xbin);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        prev  = {bout, diff};
        start = 1'b1;
        a     = xa;
        b     = xb;
        bin   = xbin;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        busy_cnt = int'(busy);
        hold_bad = ({bout, diff} !== prev) ? 1 : 0;
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) break;
            busy_cnt += int'(busy);
            if (busy === 1'b1 && {bout, diff} !== prev) hold_bad++;
        end
        check({tag, " latency"}, edges, 4);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " hold"}, hold_bad, 0);
        check({tag, " diff"}, diff, exp[3:0]);
        check({tag, " bout"}, bout, exp[4]);
        @(negedge clk);
        check({tag, " done_pulse"}, {done, ready}, 2'b01);
    endtask

    initial begin
        int         dcnt;
        int         acc_n;
        int         acc_t[4];
        logic [4:0] res[4];
        logic [4:0] got;
        logic       acc_now;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #2;
        check("in_reset", {ready, busy, done, bout, diff}, {3'b100, 5'd0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d", i), {ready, busy, done, bout, diff}, {3'b100, 5'd0});
        end

        do_op(4'd7, 4'd3, 1'b0, "7-3");
        do_op(4'd3, 4'd7, 1'b0, "3-7");
        do_op(4'd0, 4'd0, 1'b1, "0-0-1");
        do_op(4'd15, 4'd15, 1'b0, "15-15");

        // Start while busy must be ignored.
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd2;
        bin   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0;
        got  = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcnt++;
                got = {bout, diff};
            end
            if (i == 1) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end
            if (i == 2) start = 1'b0;
        end
        check("busy_start dones", dcnt, 1);
        check("busy_start result", got, 5'd7);

        // Back-to-back with start held high.
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd1;
        bin   = 1'b0;
        acc_n = 0;
        dcnt  = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 && dcnt < 4) begin
                res[dcnt] = {bout, diff};
                dcnt++;
            end
            acc_now = (ready === 1'b1) && start;
            if (acc_now && acc_n < 4) begin
                acc_t[acc_n] = i;
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (acc_n == 1) begin
                    a = 4'd2;
                    b = 4'd5;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("b2b accepts", acc_n, 2);
        check("b2b spacing", (acc_n >= 2) ? acc_t[1] - acc_t[0] : -1, 6);
        check("b2b dones", dcnt, 2);
        check("b2b first", (dcnt >= 1) ? res[0] : 5'h1f, 5'd4);
        check("b2b second", (dcnt >= 2) ? res[1] : 5'h00, 5'd29);

        // Reset during the second SHIFT cycle.
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_abort busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort outputs", {ready, busy, done, bout, diff}, {3'b100, 5'd0});
        @(negedge clk);
        #3 rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || diff !== 4'd0 || bout !== 1'b0) dcnt++;
        end
        check("abort no_done", dcnt, 0);
        do_op(4'd8, 4'd8, 1'b0, "8-8");

        // Exhaustive sweep.
        for (int i = 0; i < 512; i++) begin
            do_op(4'(i >> 5), 4'(i >> 1), 1'(i), $sformatf("sw%0d", i));
        end

        // Randomized operands.
        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        check("onehot", onehot_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
